// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: walks an external 1-bit ALU slice LSB-first, recirculating
// the carry, and assembles result/zero/carry/overflow with an SLT fix-up pass.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             err_o,
    output logic             slice_src1_o,
    output logic             slice_src2_o,
    output logic             slice_cin_o,
    output logic             slice_a_inv_o,
    output logic             slice_b_inv_o,
    output logic [1:0]       slice_op_o,
    output logic             slice_less_o,
    output logic             slice_equal_o,
    output logic [2:0]       slice_comp_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SET,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a, b, work, work_next;
    logic [3:0]       ctrl;
    logic [CW-1:0]    cnt;
    logic             carry, cin_msb, ovf_work, cout_work;
    logic [WIDTH-1:0] result_q;
    logic             cout_q, ovf_q, err_q;

    logic legal_in, is_slt, arith, last, ovf_now, cout_now;

    always_comb begin
        legal_in = (ctrl_i == 4'b0000) || (ctrl_i == 4'b0001) || (ctrl_i == 4'b0010) ||
                   (ctrl_i == 4'b0110) || (ctrl_i == 4'b0111) || (ctrl_i == 4'b1100);
        is_slt   = (ctrl == 4'b0111);
        arith    = (ctrl[1:0] == 2'b10) || is_slt;
        last     = (cnt == LAST);
        ovf_now  = arith & (cin_msb ^ slice_cout_i);
        cout_now = arith & slice_cout_i;
        work_next      = work;
        work_next[cnt] = slice_result_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        req_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        slice_src1_o  = 1'b0;
        slice_src2_o  = 1'b0;
        slice_cin_o   = 1'b0;
        slice_a_inv_o = 1'b0;
        slice_b_inv_o = 1'b0;
        slice_op_o    = 2'b00;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_next = legal_in ? RUN : DONE;
            end
            RUN: begin
                slice_src1_o  = a[cnt];
                slice_src2_o  = b[cnt];
                slice_a_inv_o = ctrl[3];
                slice_b_inv_o = ctrl[2];
                // SLT runs the slice as a subtract; the less input is never used
                slice_op_o    = is_slt ? 2'b10 : ctrl[1:0];
                slice_cin_o   = (cnt == '0) ? ctrl[2] : carry;
                if (last) state_next = is_slt ? SET : DONE;
            end
            SET: state_next = DONE;
            DONE: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // result_q and flags only load on the transition into DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a         <= '0;
            b         <= '0;
            ctrl      <= '0;
            cnt       <= '0;
            work      <= '0;
            carry     <= 1'b0;
            cin_msb   <= 1'b0;
            ovf_work  <= 1'b0;
            cout_work <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        a         <= src1_i;
                        b         <= src2_i;
                        ctrl      <= ctrl_i;
                        cnt       <= '0;
                        work      <= '0;
                        carry     <= 1'b0;
                        cin_msb   <= 1'b0;
                        ovf_work  <= 1'b0;
                        cout_work <= 1'b0;
                        if (!legal_in) begin
                            result_q <= '0;
                            cout_q   <= 1'b0;
                            ovf_q    <= 1'b0;
                            err_q    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    work  <= work_next;
                    carry <= slice_cout_i;
                    if (cnt == PENULT) cin_msb <= slice_cout_i;
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        ovf_work  <= ovf_now;
                        cout_work <= cout_now;
                        if (!is_slt) begin
                            result_q <= work_next;
                            cout_q   <= cout_now;
                            ovf_q    <= ovf_now;
                            err_q    <= 1'b0;
                        end
                    end
                end
                SET: begin
                    result_q <= {{(WIDTH-1){1'b0}}, work[WIDTH-1] ^ ovf_work};
                    cout_q   <= cout_work;
                    ovf_q    <= ovf_work;
                    err_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result_o      = result_q;
    assign zero_o        = (result_q == '0);
    assign cout_o        = cout_q;
    assign overflow_o    = ovf_q;
    assign err_o         = err_q;
    assign slice_less_o  = 1'b0;
    assign slice_equal_o = 1'b0;
    assign slice_comp_o  = 3'b000;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: behavioural 1-bit slice plus a word-level reference model,
// directed corner cases followed by randomized requests.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    ctrl = '0;
    logic [W-1:0]  src1 = '0, src2 = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  result;
    logic          zero, cout, overflow, err;
    logic          s_src1, s_src2, s_cin, s_ainv, s_binv;
    logic [1:0]    s_op;
    logic          s_less, s_equal;
    logic [2:0]    s_comp;
    logic          s_result, s_cout;

    int tests = 0;
    int fails = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .ctrl_i(ctrl), .src1_i(src1), .src2_i(src2),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .result_o(result), .zero_o(zero), .cout_o(cout), .overflow_o(overflow), .err_o(err),
        .slice_src1_o(s_src1), .slice_src2_o(s_src2), .slice_cin_o(s_cin),
        .slice_a_inv_o(s_ainv), .slice_b_inv_o(s_binv), .slice_op_o(s_op),
        .slice_less_o(s_less), .slice_equal_o(s_equal), .slice_comp_o(s_comp),
        .slice_result_i(s_result), .slice_cout_i(s_cout)
    );

    always #5 clk = ~clk;

    // 1-bit ALU slice
    logic sa, sb;
    always_comb begin
        sa       = s_src1 ^ s_ainv;
        sb       = s_src2 ^ s_binv;
        s_result = 1'b0;
        case (s_op)
            2'd0: s_result = sa & sb;
            2'd1: s_result = sa | sb;
            2'd2: s_result = sa ^ sb ^ s_cin;
            default: s_result = s_less;
        endcase
        s_cout = (sa & sb) | (sa & s_cin) | (sb & s_cin);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic co, output logic ov,
                                  output logic er);
        longint unsigned s;
        co = 1'b0; ov = 1'b0; er = 1'b0; r = '0;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin
                s  = longint'(x) + longint'(y);
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            4'b0110, 4'b0111: begin
                s  = longint'(x) + longint'(W'(~y)) + 64'd1;
                r  = s[W-1:0];
                co = s[W];
                ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
                if (c == 4'b0111) r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            end
            default: er = 1'b1;
        endcase
    endfunction

    logic [W-1:0] exp_r;
    logic         exp_c, exp_v, exp_e;

    // Issue one request, wait for the response and check it; response is left pending.
    task automatic run_req(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        int cycles;
        int bad;
        int lat;
        logic [1:0] op_exp;
        model(c, x, y, exp_r, exp_c, exp_v, exp_e);
        lat    = exp_e ? 0 : ((c == 4'b0111) ? W + 1 : W);
        op_exp = (c == 4'b0111) ? 2'd2 : c[1:0];
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; ctrl = c; src1 = x; src2 = y;
        @(posedge clk); #1;
        req_valid = 1'b0; src1 = $urandom; src2 = $urandom; ctrl = 4'($urandom);
        cycles = 0; bad = 0;
        while (resp_valid !== 1'b1 && cycles < 100) begin
            if (cycles < W) begin
                if (s_src1 !== x[cycles] || s_src2 !== y[cycles] || s_ainv !== c[3] ||
                    s_binv !== c[2] || s_op !== op_exp || req_ready !== 1'b0) bad++;
                if (cycles == 0 && s_cin !== c[2]) bad++;
            end else if ({s_src1, s_src2, s_cin, s_ainv, s_binv, s_op} !== '0) bad++;
            if ({s_less, s_equal, s_comp} !== '0) bad++;
            @(posedge clk); #1;
            cycles++;
        end
        check("latency", 64'(cycles), 64'(lat));
        check("slice_drive", 64'(bad), 64'd0);
        @(negedge clk);
        check("result", 64'(result), 64'(exp_r));
        check("zero", 64'(zero), 64'(exp_r == '0));
        check("cout", 64'(cout), 64'(exp_c));
        check("overflow", 64'(overflow), 64'(exp_v));
        check("err", 64'(err), 64'(exp_e));
        check("slice_idle", 64'({s_src1, s_src2, s_cin, s_ainv, s_binv, s_op}), 64'd0);
    endtask

    task automatic release_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_valid_drop", 64'(resp_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'({zero, cout, overflow, err}), 64'b1000);
        check("rst_slice", 64'({s_src1, s_src2, s_cin, s_ainv, s_binv, s_op, s_less, s_equal, s_comp}), 64'd0);
    endtask

    logic [3:0] legal [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    initial begin
        logic [W-1:0] x, y, held;
        logic [3:0]   c;
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        @(negedge clk) rst = 1'b1;

        run_req(4'b0010, 32'd5, 32'd7);                 release_resp();
        run_req(4'b0110, 32'd5, 32'd7);                 release_resp();
        run_req(4'b0110, 32'd7, 32'd7);                 release_resp();
        run_req(4'b0111, 32'hFFFF_FFFF, 32'd1);         release_resp();
        run_req(4'b0111, 32'h8000_0000, 32'd1);         release_resp();
        run_req(4'b0111, 32'd3, 32'd2);                 release_resp();
        run_req(4'b0010, 32'h7FFF_FFFF, 32'd1);         release_resp();
        run_req(4'b1100, 32'd0, 32'd0);                 release_resp();
        run_req(4'b0101, 32'd9, 32'd3);                 release_resp();
        run_req(4'b0000, 32'hF0F0_A5A5, 32'h3C3C_FFFF); release_resp();
        run_req(4'b0001, 32'h0000_1234, 32'h8000_0000); release_resp();

        // response held: outputs stable, new requests ignored
        run_req(4'b0010, 32'h1234_5678, 32'h1111_1111);
        held = result;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1; ctrl = 4'b0001; src1 = $urandom; src2 = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_ready", 64'(req_ready), 64'd0);
            check("hold_result", 64'(result), 64'(held));
        end
        req_valid = 1'b0;
        release_resp();
        run_req(4'b0110, 32'd100, 32'd1);               release_resp();

        for (int i = 0; i < 24; i++) begin
            c = legal[$urandom_range(0, 5)];
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 5))
                0: x = 32'h8000_0000;
                1: y = x;
                2: y = 32'h7FFF_FFFF;
                default: ;
            endcase
            run_req(c, x, y);
            release_resp();
        end
        run_req(4'b1010, $urandom, $urandom);           release_resp();

        // reset in the middle of an addition
        @(negedge clk);
        req_valid = 1'b1; ctrl = 4'b0010; src1 = 32'h1234_5678; src2 = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values();
        @(negedge clk) rst = 1'b1;
        run_req(4'b0010, 32'd1, 32'd1);                 release_resp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
